// File: rtl/hash_table.sv
// Shared hash-table parameters used by the insert/delete engines and the free-list manager.
// Pure declarations, no logic and no latency.
// No flow control.
package hash_table;

  // Data-RAM address width, shared by every engine touching the data RAM.
  localparam int TABLE_ADDR_WIDTH = 4;

  // Number of free-list entries: one per data-RAM address.
  localparam int EMPTY_PTR_DEPTH = 2**TABLE_ADDR_WIDTH;

  // Free-list manager state.
  typedef enum logic {
    INIT_S = 1'b0,
    RUN_S  = 1'b1
  } eps_state_t;

endpackage

// File: rtl/empty_ptr_storage.sv
// Free-list of data-RAM pointers: self-fills with every address after reset, then runs as a circular FIFO.
// Latency: a push into an empty list is visible on next_empty_ptr_o one cycle later; head is read combinationally.
// Backpressure: none; pushes when full (without a same-cycle pop) are dropped and flagged, acks with no valid pointer are flagged.
module empty_ptr_storage
  import hash_table::*;
#(
  parameter int A_WIDTH = TABLE_ADDR_WIDTH,
  parameter int DEPTH   = 2**A_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               overflow_err_o,
  output logic               underflow_err_o
);

  localparam logic [A_WIDTH:0]   FULL_CNT = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH:0]   CNT_ONE  = (A_WIDTH+1)'(1);
  localparam logic [A_WIDTH-1:0] PTR_ONE  = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(DEPTH-1);

  eps_state_t         state;
  logic [A_WIDTH-1:0] init_cnt;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH:0]   cnt;

  logic [A_WIDTH-1:0] mem [DEPTH];

  logic               head_vld;
  logic               pop;
  logic               push_acc;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [A_WIDTH-1:0] mem_wdata;

  // A pointer is only offered once init has finished and the list is non-empty.
  assign head_vld = (state == RUN_S) && (cnt != '0);
  assign pop      = head_vld && next_empty_ptr_rd_ack_i;
  // When full, a push still fits if the head leaves in the same cycle.
  assign push_acc = (state == RUN_S) && add_empty_ptr_en_i && ((cnt != FULL_CNT) || pop);

  assign next_empty_ptr_val_o = head_vld;
  assign next_empty_ptr_o     = head_vld ? mem[rd_ptr] : '0;
  assign free_cnt_o           = cnt;

  // Storage write port: identity fill during init, returned pointers afterwards.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = add_empty_ptr_i;
    if (state == INIT_S) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = init_cnt;
    end else if (push_acc) begin
      mem_we    = 1'b1;
    end
  end

  // Pointer storage; contents are not reset because init rewrites every entry.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM: init fill sequence, FIFO pointers/count and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= INIT_S;
      init_cnt        <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      cnt             <= '0;
      init_done_o     <= 1'b0;
      overflow_err_o  <= 1'b0;
      underflow_err_o <= 1'b0;
    end else begin
      if (add_empty_ptr_en_i && !push_acc) begin
        overflow_err_o <= 1'b1;
      end
      if (next_empty_ptr_rd_ack_i && !head_vld) begin
        underflow_err_o <= 1'b1;
      end
      case (state)
        INIT_S: begin
          init_cnt <= init_cnt + PTR_ONE;
          cnt      <= cnt + CNT_ONE;
          // wr_ptr stays 0: after DEPTH writes it has logically wrapped back there.
          if (init_cnt == LAST_IDX) begin
            state       <= RUN_S;
            init_done_o <= 1'b1;
          end
        end
        RUN_S: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
          end
          if (push_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
          end
          case ({push_acc, pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
          endcase
        end
        default: state <= INIT_S;
      endcase
    end
  end

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Directed bench for the free-list manager with hand-computed expectations and a small scoreboard queue.
// Inputs change and outputs are sampled on the falling clock edge.
// Summary line reports total checks and errors.
module tb_empty_ptr_storage;
  import hash_table::*;

  localparam int AW = TABLE_ADDR_WIDTH;
  localparam int DP = EMPTY_PTR_DEPTH;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] add_ptr;
  logic          add_en;
  logic [AW-1:0] nxt_ptr;
  logic          nxt_val;
  logic          rd_ack;
  logic          init_done;
  logic [AW:0]   free_cnt;
  logic          ovf_err;
  logic          udf_err;

  int checks;
  int errors;

  empty_ptr_storage #(.A_WIDTH(AW), .DEPTH(DP)) dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .add_empty_ptr_i         (add_ptr),
    .add_empty_ptr_en_i      (add_en),
    .next_empty_ptr_o        (nxt_ptr),
    .next_empty_ptr_val_o    (nxt_val),
    .next_empty_ptr_rd_ack_i (rd_ack),
    .init_done_o             (init_done),
    .free_cnt_o              (free_cnt),
    .overflow_err_o          (ovf_err),
    .underflow_err_o         (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs for one rising edge, return at the next falling edge.
  task automatic tick(input logic en, input logic [AW-1:0] p, input logic ack);
    add_en  = en;
    add_ptr = p;
    rd_ack  = ack;
    @(negedge clk);
    add_en  = 1'b0;
    add_ptr = '0;
    rd_ack  = 1'b0;
  endtask

  logic [AW-1:0] sb_q [$];
  logic [AW-1:0] val_v;

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    add_en  = 1'b0;
    add_ptr = '0;
    rd_ack  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_init_done", int'(init_done), 0);
    check("rst_free_cnt", int'(free_cnt), 0);
    check("rst_val", int'(nxt_val), 0);
    check("rst_ptr", int'(nxt_ptr), 0);
    check("rst_ovf", int'(ovf_err), 0);
    check("rst_udf", int'(udf_err), 0);

    // Init sequence: 16 edges after release
    rst_n = 1'b1;
    for (int i = 0; i < DP-1; i++) tick(1'b0, '0, 1'b0);
    check("init_done_early", int'(init_done), 0);
    check("init_val_early", int'(nxt_val), 0);
    check("init_cnt_15", int'(free_cnt), DP-1);
    tick(1'b0, '0, 1'b0);
    check("init_done", int'(init_done), 1);
    check("init_free_cnt", int'(free_cnt), DP);
    check("init_val", int'(nxt_val), 1);
    check("init_head", int'(nxt_ptr), 0);

    // Drain: identity order 0..15
    for (int i = 0; i < DP; i++) begin
      check("drain_val", int'(nxt_val), 1);
      check("drain_ptr", int'(nxt_ptr), i);
      tick(1'b0, '0, 1'b1);
    end
    check("empty_val", int'(nxt_val), 0);
    check("empty_cnt", int'(free_cnt), 0);
    check("empty_ptr", int'(nxt_ptr), 0);
    check("no_udf_yet", int'(udf_err), 0);
    tick(1'b0, '0, 1'b1);
    check("udf_set", int'(udf_err), 1);
    check("udf_cnt", int'(free_cnt), 0);

    // Push into empty list
    tick(1'b1, 4'd5, 1'b0);
    check("push5_val", int'(nxt_val), 1);
    check("push5_ptr", int'(nxt_ptr), 5);
    check("push5_cnt", int'(free_cnt), 1);
    check("no_ovf_yet", int'(ovf_err), 0);

    // Fill: list becomes 5,0,1,...,14
    for (int i = 0; i < DP-1; i++) begin
      val_v = AW'(i);
      tick(1'b1, val_v, 1'b0);
    end
    check("full_cnt", int'(free_cnt), DP);
    tick(1'b1, 4'd3, 1'b0);
    check("full_drop_ovf", int'(ovf_err), 1);
    check("full_drop_cnt", int'(free_cnt), DP);
    check("full_drop_head", int'(nxt_ptr), 5);
    // Push while full with simultaneous pop: 5 leaves, 3 joins the tail
    tick(1'b1, 4'd3, 1'b1);
    check("full_pp_cnt", int'(free_cnt), DP);
    for (int i = 0; i < DP-1; i++) begin
      check("full_pp_order", int'(nxt_ptr), i);
      tick(1'b0, '0, 1'b1);
    end
    check("full_pp_tail_val", int'(nxt_val), 1);
    check("full_pp_tail", int'(nxt_ptr), 3);
    tick(1'b0, '0, 1'b1);
    check("full_pp_empty", int'(free_cnt), 0);

    // Mixed push/pop over 40 cycles; pointers wrap past the end of the array
    for (int i = 0; i < 40; i++) begin
      logic en;
      logic ack;
      en    = (i % 3) != 2;
      ack   = (i % 3) != 0;
      val_v = AW'((i * 7 + 3) % DP);
      check("mix_val", int'(nxt_val), int'(sb_q.size() != 0));
      if (ack && sb_q.size() != 0) begin
        check("mix_pop", int'(nxt_ptr), int'(sb_q.pop_front()));
      end
      if (en) sb_q.push_back(val_v);
      tick(en, val_v, ack);
      check("mix_cnt", int'(free_cnt), sb_q.size());
    end
    while (sb_q.size() != 0) begin
      check("mix_tail", int'(nxt_ptr), int'(sb_q.pop_front()));
      tick(1'b0, '0, 1'b1);
    end
    check("mix_done_cnt", int'(free_cnt), 0);

    // Fresh init, drain to 7, then asynchronous reset mid-drain
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DP; i++) tick(1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, '0, 1'b1);
    check("mid_cnt", int'(free_cnt), 7);
    check("mid_head", int'(nxt_ptr), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", int'(free_cnt), 0);
    check("arst_val", int'(nxt_val), 0);
    check("arst_ptr", int'(nxt_ptr), 0);
    check("arst_done", int'(init_done), 0);
    check("arst_udf", int'(udf_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Push and ack during init: both dropped and flagged
    tick(1'b1, 4'd9, 1'b1);
    check("init_push_ovf", int'(ovf_err), 1);
    check("init_ack_udf", int'(udf_err), 1);
    for (int i = 1; i < DP-1; i++) tick(1'b0, '0, 1'b0);
    check("reinit_early", int'(init_done), 0);
    tick(1'b0, '0, 1'b0);
    check("reinit_done", int'(init_done), 1);
    check("reinit_cnt", int'(free_cnt), DP);
    check("reinit_head", int'(nxt_ptr), 0);
    tick(1'b0, '0, 1'b1);
    check("reinit_second", int'(nxt_ptr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
